neuron_layer_seq: RTL
=====================

# neuron_layer_seq

Sequential fixed-point neuron layer: N neurons share one streamed input `H` and each accumulates an S-step dot product of `H` with its own weight stream, plus a per-neuron bias. It adds a valid/ready handshake, a step counter, output saturation and an optional activation to the parallel-MAC layer in the neuron datapath. It sits between the hidden-state buffer (producer of `H`/`W` beats) and the next layer (consumer of `Y`).

## Interface
- `N`, 8, neuron count (channels)
- `S`, 8, beats per dot product (≥2)
- `n`, 16, data width, signed two's complement
- `FRAC`, 8, fractional bits of `H`, `W`, `B`, `Y` (Q(n-FRAC).FRAC)
- `ACCW`, 40, accumulator width (≥ 2n)

- `clk` in 1, clock, rising edge
- `reset` in 1, asynchronous active-low reset
- `in_valid` in 1, beat valid
- `in_ready` out 1, layer can accept a beat
- `H` in n, shared input sample
- `W` in N*n, weights; neuron i uses `W[n*(i+1)-1 -: n]`
- `B` in N*n, biases, sampled only on beat 0
- `out_valid` out 1, `Y` holds a result
- `out_ready` in 1, consumer accepts `Y`
- `Y` out N*n, saturated results, same slicing as `W`
- `busy` out 1, at least one beat of the current dot product accepted

## Operation
- States: ACC (`in_ready`=1, `out_valid`=0), HOLD (`in_ready`=0, `out_valid`=1).
- Beat accepted when `in_valid && in_ready`; non-accepted cycles leave all state unchanged.
- Term_i = (H × W_i), 2n-bit signed product, arithmetic right shift by FRAC (rounding toward −∞), sign-extended to ACCW.
- Step counter `k` from 0 to S−1. On an accepted beat with k=0: acc_i = sext(B_i << FRAC… no shift, B_i sign-extended) + term_i. With 0<k<S−1: acc_i += term_i. Accumulator wraps mod 2^ACCW and does not saturate internally.
- At k=S−1: final_i = acc_i + term_i, saturated to [−2^(n−1), 2^(n−1)−1], registered into `Y`; k←0; state → HOLD.
- HOLD: `Y` and `out_valid` stay stable until `out_ready`=1; on that edge `out_valid`←0, state → ACC. `in_ready` is 0 for the whole of HOLD, including the cycle where `out_ready` is sampled.
- `busy` = (k≠0) in ACC.
- Reset (any time, including mid-accumulation or in HOLD): state ACC, k=0, all acc=0, `Y`=0, `out_valid`=0, `in_ready`=1 once reset is released, `busy`=0. Partial sums are discarded.

## Timing
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `in_valid` or `out_ready`.
- Latency: `out_valid` rises on the edge that accepts beat S−1. `Y` is visible the cycle after that beat.
- Minimum period per result is S+1 cycles: S beats, then 1 HOLD cycle with `out_ready` held high.
- `in_valid` gaps may occur between any beats. The counter advances only on accepted beats.
- Inputs `H`, `W`, `B` are don't-care when `in_valid`=0.

## Configuration
- `NEURON_RELU_EN` defined: after saturation, any negative final_i is replaced by 0, so `Y` ∈ [0, 2^(n−1)−1].
- Not defined: `Y` is the saturated signed result, with negatives passed through.

## Test plan
Default bench: N=2, S=4, n=16, FRAC=8.
- Basic: `H`=0x0100 (1.0), W0=0x0200 (2.0), W1=0xFF00 (−1.0), B=0 for 4 consecutive beats → `out_valid` on the 4th accept edge, Y0=0x0800, Y1=0xFC00 (0x0000 with RELU).
- Bias and gaps: B0=0x0080 (0.5) on beat 0, `H`=W0=0x0100, `in_valid` low 2 cycles between beats 1 and 2 → Y0=0x0480 (4.5), result after exactly 4 accepts.
- Saturation: `H`=W0=0x7FFF, W1=0x8000, 4 beats → Y0=0x7FFF, Y1=0x8000 (0x0000 with RELU).
- Backpressure: `out_ready` low 5 cycles after the result → `in_ready`=0, `Y` stable, `out_valid`=1 throughout. Then `out_ready`=1 → next cycle `in_ready`=1 and a second dot product gives correct values.
- Reset mid-operation: accept 2 beats (W0=0x7FFF), assert `reset` for 1 cycle, then 4 beats per the basic case → Y0=0x0800 with no residue, and `busy` is 0 right after reset.
- Reset in HOLD: `out_valid`=1, assert `reset` → `out_valid`=0, `Y`=0, `in_ready`=1 after release.

Source files
------------

// File: rtl/neuron_layer_seq_if.sv
// Beat/result handshake bundle for neuron_layer_seq: producer beats (H/W/B) in,
// saturated results (Y) out. The layer itself uses the slave modport.
interface neuron_layer_seq_if #(
    parameter int N = 8,
    parameter int n = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [n-1:0]   H;
    logic [N*n-1:0] W;
    logic [N*n-1:0] B;
    logic           out_valid;
    logic           out_ready;
    logic [N*n-1:0] Y;
    logic           busy;

    modport master (
        output in_valid, H, W, B, out_ready,
        input  in_ready, out_valid, Y, busy
    );

    modport slave (
        input  in_valid, H, W, B, out_ready,
        output in_ready, out_valid, Y, busy
    );
endinterface

// File: rtl/neuron_layer_seq.sv
// Sequential fixed-point neuron layer: N neurons accumulate S-beat dot products of a
// shared H with per-neuron W plus bias, saturate to n bits. Optional ReLU: NEURON_RELU_EN.
module neuron_layer_seq #(
    parameter int N    = 8,
    parameter int S    = 8,
    parameter int n    = 16,
    parameter int FRAC = 8,
    parameter int ACCW = 40
) (
    input  logic              clk,
    input  logic              reset,
    neuron_layer_seq_if.slave io
);
    localparam int KW = $clog2(S);
    localparam int PW = 2 * n;
    localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
    localparam logic [KW-1:0] K_LAST = KW'(S - 1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [KW-1:0]          r_k;
    logic [KW-1:0]          w_k_nxt;
    logic                   w_accept;
    logic                   w_last;
    logic signed [ACCW-1:0] r_acc [N];
    logic signed [PW-1:0]   w_prod [N];
    logic signed [ACCW-1:0] w_base [N];
    logic signed [ACCW-1:0] w_sum [N];
    logic [N*n-1:0]         w_y_nxt;
    logic [N*n-1:0]         r_y;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;

    // Clamp to the signed n-bit range, then optionally drop negatives.
    function automatic logic [n-1:0] sat_out(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] max_v;
        logic signed [ACCW-1:0] min_v;
        logic [n-1:0]           res;
        max_v = $signed({{(ACCW-n+1){1'b0}}, {(n-1){1'b1}}});
        min_v = $signed({{(ACCW-n+1){1'b1}}, {(n-1){1'b0}}});
        if (v > max_v) begin
            res = {1'b0, {(n-1){1'b1}}};
        end else if (v < min_v) begin
            res = {1'b1, {(n-1){1'b0}}};
        end else begin
            res = v[n-1:0];
        end
`ifdef NEURON_RELU_EN
        res = res[n-1] ? {n{1'b0}} : res;
`endif
        return res;
    endfunction

    // Next-state and step-counter logic; only accepted beats move the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_accept    = (r_state == ST_ACC) && io.in_valid;
        w_last      = (r_k == K_LAST);
        case (r_state)
            ST_ACC: begin
                if (w_accept && w_last) begin
                    w_state_nxt = ST_HOLD;
                    w_k_nxt     = K_ZERO;
                end else if (w_accept) begin
                    w_k_nxt = r_k + {{(KW-1){1'b0}}, 1'b1};
                end else begin
                    w_k_nxt = r_k;
                end
            end
            ST_HOLD: begin
                if (io.out_ready) begin
                    w_state_nxt = ST_ACC;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
                w_k_nxt     = K_ZERO;
            end
        endcase
    end

    // Per-neuron term (product floored by FRAC) added to bias on beat 0, else to acc.
    always_comb begin
        w_y_nxt = {(N*n){1'b0}};
        for (int i = 0; i < N; i++) begin
            w_prod[i] = PW'($signed(io.H)) * PW'($signed(io.W[n*i +: n]));
            if (r_k == K_ZERO) begin
                w_base[i] = ACCW'($signed(io.B[n*i +: n]));
            end else begin
                w_base[i] = r_acc[i];
            end
            w_sum[i]            = w_base[i] + ACCW'(w_prod[i] >>> FRAC);
            w_y_nxt[n*i +: n]   = sat_out(w_sum[i]);
        end
    end

    // FSM state and step counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACC;
            r_k     <= K_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Accumulators and result register, written only on accepted beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                r_acc[i] <= {ACCW{1'b0}};
            end
            r_y <= {(N*n){1'b0}};
        end else if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                r_acc[i] <= w_sum[i];
            end
            if (w_last) begin
                r_y <= w_y_nxt;
            end
        end
    end

    // Handshake flags registered from the next state, so no input-to-output path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_ACC);
            r_out_valid <= (w_state_nxt == ST_HOLD);
            r_busy      <= (w_state_nxt == ST_ACC) && (w_k_nxt != K_ZERO);
        end
    end

    assign io.in_ready  = r_in_ready;
    assign io.out_valid = r_out_valid;
    assign io.busy      = r_busy;
    assign io.Y         = r_y;
endmodule
